// File: rtl/cmp_pkg.sv
// Shared types and helpers for the chunked sequential comparator.
// Holds the FSM state encoding, the one-hot result encoding and the signed MSB flip.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result flags packed as {lt, eq, gt}; NONE is the idle/cleared value
  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] LT   = 3'b100;
  localparam logic [2:0] EQ   = 3'b010;
  localparam logic [2:0] GT   = 3'b001;

  localparam int MAX_CHUNK = 64;

  // Flipping the sign bit of both operands turns a two's-complement compare into an unsigned one
  function automatic logic [MAX_CHUNK-1:0] flip_msb(input logic [MAX_CHUNK-1:0] value,
                                                    input int unsigned         width);
    return value ^ (MAX_CHUNK'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/chunk_compare_slice.sv
// Combinational CHUNK-bit unsigned magnitude compare with optional sign-bit inversion.
// Produces exactly one of lt/eq/gt for any input pair.
module chunk_compare_slice
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_invert,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [MAX_CHUNK-1:0] a_ext;
  logic [MAX_CHUNK-1:0] b_ext;

  always_comb begin
    a_ext = MAX_CHUNK'(a);
    b_ext = MAX_CHUNK'(b);
    if (msb_invert) begin
      a_ext = flip_msb(a_ext, CHUNK);
      b_ext = flip_msb(b_ext, CHUNK);
    end
  end

  assign lt = (a_ext <  b_ext);
  assign eq = (a_ext == b_ext);
  assign gt = (a_ext >  b_ext);

endmodule

// File: rtl/chunked_comparator_seq.sv
// MSB-first sequential comparator: one CHUNK-bit slice per cycle, stops at the first
// unequal chunk, and exposes the active slice on a one-hot gate_en for power gating.
module chunked_comparator_seq
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = $clog2(NCHUNK + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic              signed_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              less_than,
  output logic              equal_to,
  output logic              greater_than,
  output logic [CW-1:0]     chunks_used,
  output logic [NCHUNK-1:0] gate_en
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              mode_q, mode_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     used_q, used_d;
  logic [2:0]        res_q, res_d;
  logic              valid_q, valid_d;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic              msb_inv;
  logic              slice_lt, slice_eq, slice_gt;

  // Select the active slice; only this slice of the operand registers feeds the comparator
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    gate_en = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_chunk    = a_q[i*CHUNK +: CHUNK];
        b_chunk    = b_q[i*CHUNK +: CHUNK];
        gate_en[i] = (state_q == RUN);
      end
    end
  end

  assign msb_inv = mode_q && (idx_q == IW'(NCHUNK - 1));

  chunk_compare_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a         (a_chunk),
    .b         (b_chunk),
    .msb_invert(msb_inv),
    .lt        (slice_lt),
    .eq        (slice_eq),
    .gt        (slice_gt)
  );

  assign in_ready = (state_q == IDLE) && !reset;

  // Next-state and datapath updates; registers hold unless the current state acts on them
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    count_d = count_q;
    used_d  = used_q;
    res_d   = res_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a_in;
          b_d     = b_in;
          mode_d  = signed_mode;
          idx_d   = IW'(NCHUNK - 1);
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        count_d = count_q + CW'(1);
        if (!slice_eq) begin
          res_d   = slice_lt ? LT : (slice_gt ? GT : NONE);
          used_d  = count_q + CW'(1);
          valid_d = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = EQ;
          used_d  = CW'(NCHUNK);
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = NONE;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
      used_q  <= '0;
      res_q   <= NONE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      used_q  <= used_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid    = valid_q;
  assign less_than    = res_q[2];
  assign equal_to     = res_q[1];
  assign greater_than = res_q[0];
  assign chunks_used  = used_q;

endmodule
